// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Receive-side buffer behind an 8N1 UART receiver. It takes each finished
//   byte through the receiver's rx_done/rx_read handshake and stores it in a
//   power-of-two FIFO. The bytes leave as a valid/ready stream. The block
//   also reports bytes dropped while the FIFO was full, and raises a pulse
//   once the line has been idle for a set time after the last byte.
//
// Ports
//   clk, rst        clock; synchronous active-low reset
//   rx_done/rx_byte receiver byte-ready level flag and its data
//   rx_read         registered one-cycle acknowledge back to the receiver
//   out_valid/out_data/out_ready
//                   consumer stream; out_data reads 0 while the FIFO is empty
//   level           current FIFO occupancy, 0..DEPTH
//   overrun         sticky flag, set when a byte is dropped on a full FIFO
//   drop_count      number of dropped bytes, saturating at 255
//   clr_overrun     clears overrun and drop_count
//   idle_cycles     idle timeout in clk cycles; 0 turns the timer off
//   idle_pulse      one-cycle pulse, idle_cycles cycles after the last capture
module uart_rx_fifo #(
   parameter int DEPTH = 16,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          rx_done,
   input  logic [7:0]    rx_byte,
   output logic          rx_read,
   output logic          out_valid,
   output logic [7:0]    out_data,
   input  logic          out_ready,
   output logic [CW-1:0] level,
   output logic          overrun,
   output logic [7:0]    drop_count,
   input  logic          clr_overrun,
   input  logic [23:0]   idle_cycles,
   output logic          idle_pulse
);

   localparam int AW = $clog2(DEPTH);

   localparam logic [1:0] WAIT_DONE = 2'd0;
   localparam logic [1:0] ACK       = 2'd1;
   localparam logic [1:0] CLEAR     = 2'd2;

   localparam logic [CW-1:0] FULL_LEVEL = CW'(DEPTH);

   logic [1:0]    state;
   logic [1:0]    state_nxt;
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          capture;
   logic          push;
   logic          pop;
   logic          drop;
   logic [23:0]   idle_timer;
   logic          idle_armed;

   // Capture FSM
   assign capture = (state == WAIT_DONE) && rx_done;

   always_comb begin
      state_nxt = state;
      case (state)
         WAIT_DONE: if (rx_done)  state_nxt = ACK;
         ACK:                     state_nxt = CLEAR;
         CLEAR:     if (!rx_done) state_nxt = WAIT_DONE;
         default:                 state_nxt = WAIT_DONE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= WAIT_DONE;
         rx_read <= 1'b0;
      end else begin
         state   <= state_nxt;
         rx_read <= capture;
      end
   end

   // FIFO. A full FIFO still accepts a byte when a pop frees a slot in the same cycle.
   assign out_valid = (level != '0);
   assign out_data  = out_valid ? mem[rd_ptr] : '0;
   assign pop       = out_valid && out_ready;
   assign push      = capture && ((level != FULL_LEVEL) || pop);
   assign drop      = capture && !push;

   always_ff @(posedge clk) begin
      if (rst && push) mem[wr_ptr] <= rx_byte;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   // Overrun tracking. A drop in the same cycle as a clear restarts the count at 1.
   always_ff @(posedge clk) begin
      if (!rst) begin
         overrun    <= 1'b0;
         drop_count <= '0;
      end else if (drop) begin
         overrun <= 1'b1;
         if (clr_overrun)
            drop_count <= 8'd1;
         else if (drop_count != 8'hFF)
            drop_count <= drop_count + 8'd1;
      end else if (clr_overrun) begin
         overrun    <= 1'b0;
         drop_count <= '0;
      end
   end

   // Idle timer. It restarts on every capture. The pulse fires when the timer
   // reaches idle_cycles-1, which is idle_cycles cycles after the capture cycle.
   assign idle_pulse = idle_armed && (idle_cycles != '0) &&
                       (idle_timer == idle_cycles - 24'd1);

   always_ff @(posedge clk) begin
      if (!rst) begin
         idle_timer <= '0;
         idle_armed <= 1'b0;
      end else if (capture) begin
         idle_timer <= '0;
         idle_armed <= 1'b1;
      end else if (idle_cycles == '0) begin
         idle_timer <= '0;
      end else if (idle_pulse) begin
         idle_timer <= '0;
         idle_armed <= 1'b0;
      end else if (idle_armed) begin
         idle_timer <= idle_timer + 24'd1;
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo
//   Self-checking bench for uart_rx_fifo with DEPTH=4. A queue holds the
//   expected FIFO contents. A byte is added to it when the receiver model
//   offers that byte and the model judges that it will be accepted. An entry
//   is taken off the queue and compared when the consumer pops a byte.
module tb_uart_rx_fifo;

   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          rx_done = 1'b0;
   logic [7:0]    rx_byte = '0;
   logic          rx_read;
   logic          out_valid;
   logic [7:0]    out_data;
   logic          out_ready = 1'b0;
   logic [CW-1:0] level;
   logic          overrun;
   logic [7:0]    drop_count;
   logic          clr_overrun = 1'b0;
   logic [23:0]   idle_cycles = '0;
   logic          idle_pulse;

   int            n_tests = 0;
   int            n_fail  = 0;
   logic [7:0]    exp_q[$];
   int            mlevel = 0;

   always #5 clk = ~clk;

   uart_rx_fifo #(.DEPTH(DEPTH), .CW(CW)) dut (
      .clk         (clk),
      .rst         (rst),
      .rx_done     (rx_done),
      .rx_byte     (rx_byte),
      .rx_read     (rx_read),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_ready   (out_ready),
      .level       (level),
      .overrun     (overrun),
      .drop_count  (drop_count),
      .clr_overrun (clr_overrun),
      .idle_cycles (idle_cycles),
      .idle_pulse  (idle_pulse)
   );

   // advance to 1 time unit after the next rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Receiver model: raise rx_done and hold it through the ACK cycle. Drop it
   // on the edge that ends the ACK cycle. Return once the FSM can take the next byte.
   task automatic send_byte(input logic [7:0] b);
      bit got;
      int lat;
      got = 1'b0;
      lat = -1;
      rx_byte = b;
      rx_done = 1'b1;
      if (mlevel < DEPTH) begin
         exp_q.push_back(b);
         mlevel++;
      end
      for (int k = 0; k < 8 && !got; k++) begin
         step();
         if (rx_read === 1'b1) begin
            got = 1'b1;
            lat = k;
         end
      end
      n_tests++;
      if (!got || lat != 0) begin
         n_fail++;
         $display("FAIL ack_latency byte %0h: got %0d expected 0 (got=%0d)", b, lat, got);
      end
      step();
      rx_done = 1'b0;
      step();
   endtask

   task automatic pop_one();
      logic [7:0] exp_b;
      n_tests++;
      if (out_valid !== 1'b1 || exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL pop_valid: out_valid %b expected 1 (queue %0d)", out_valid, exp_q.size());
      end else begin
         exp_b = exp_q.pop_front();
         n_tests++;
         if (out_data !== exp_b) begin
            n_fail++;
            $display("FAIL pop_data: got %0h expected %0h", out_data, exp_b);
         end
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      mlevel--;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      step();
      step();
      n_tests++; if (rx_read !== 1'b0)    begin n_fail++; $display("FAIL rst_rx_read: got %b expected 0", rx_read); end
      n_tests++; if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
      n_tests++; if (out_data !== 8'h00)  begin n_fail++; $display("FAIL rst_out_data: got %0h expected 0", out_data); end
      n_tests++; if (level !== '0)        begin n_fail++; $display("FAIL rst_level: got %0d expected 0", level); end
      n_tests++; if (overrun !== 1'b0)    begin n_fail++; $display("FAIL rst_overrun: got %b expected 0", overrun); end
      n_tests++; if (drop_count !== 8'h0) begin n_fail++; $display("FAIL rst_drop_count: got %0d expected 0", drop_count); end
      n_tests++; if (idle_pulse !== 1'b0) begin n_fail++; $display("FAIL rst_idle_pulse: got %b expected 0", idle_pulse); end
      rst = 1'b1;
      step();
   endtask

   task automatic test_single_byte();
      rx_byte = 8'hA5;
      rx_done = 1'b1;
      exp_q.push_back(8'hA5);
      mlevel++;
      #1;
      n_tests++; if (rx_read !== 1'b0) begin n_fail++; $display("FAIL single_rx_read_N: got %b expected 0", rx_read); end
      step();
      n_tests++; if (rx_read !== 1'b1)   begin n_fail++; $display("FAIL single_rx_read_N1: got %b expected 1", rx_read); end
      n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid_N1: got %b expected 1", out_valid); end
      n_tests++; if (out_data !== 8'hA5) begin n_fail++; $display("FAIL single_data_N1: got %0h expected a5", out_data); end
      n_tests++; if (level !== CW'(1))   begin n_fail++; $display("FAIL single_level_N1: got %0d expected 1", level); end
      step();
      rx_done = 1'b0;
      n_tests++; if (rx_read !== 1'b0) begin n_fail++; $display("FAIL single_rx_read_N2: got %b expected 0", rx_read); end
      pop_one();
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_after_pop: got %b expected 0", out_valid); end
      n_tests++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL single_data_after_pop: got %0h expected 0", out_data); end
      n_tests++; if (level !== '0)       begin n_fail++; $display("FAIL single_level_after_pop: got %0d expected 0", level); end
   endtask

   task automatic test_fill_wrap();
      for (int b = 1; b <= 4; b++) send_byte(8'(b));
      n_tests++; if (level !== CW'(4)) begin n_fail++; $display("FAIL wrap_level_full: got %0d expected 4", level); end
      pop_one();
      pop_one();
      send_byte(8'h05);
      send_byte(8'h06);
      n_tests++; if (level !== CW'(4)) begin n_fail++; $display("FAIL wrap_level_refill: got %0d expected 4", level); end
      for (int i = 0; i < 4; i++) pop_one();
      n_tests++; if (level !== '0) begin n_fail++; $display("FAIL wrap_level_empty: got %0d expected 0", level); end
   endtask

   task automatic test_overrun();
      for (int b = 1; b <= 4; b++) send_byte(8'(b));
      send_byte(8'h07);
      send_byte(8'h08);
      send_byte(8'h09);
      n_tests++; if (overrun !== 1'b1)     begin n_fail++; $display("FAIL ovr_flag: got %b expected 1", overrun); end
      n_tests++; if (drop_count !== 8'd3)  begin n_fail++; $display("FAIL ovr_count: got %0d expected 3", drop_count); end
      n_tests++; if (level !== CW'(4))     begin n_fail++; $display("FAIL ovr_level: got %0d expected 4", level); end
      clr_overrun = 1'b1;
      step();
      clr_overrun = 1'b0;
      n_tests++; if (overrun !== 1'b0)    begin n_fail++; $display("FAIL clr_flag: got %b expected 0", overrun); end
      n_tests++; if (drop_count !== 8'd0) begin n_fail++; $display("FAIL clr_count: got %0d expected 0", drop_count); end
      // a drop in the same cycle as the clear must win
      rx_byte = 8'hEE;
      rx_done = 1'b1;
      clr_overrun = 1'b1;
      step();
      clr_overrun = 1'b0;
      n_tests++; if (overrun !== 1'b1)    begin n_fail++; $display("FAIL clr_drop_flag: got %b expected 1", overrun); end
      n_tests++; if (drop_count !== 8'd1) begin n_fail++; $display("FAIL clr_drop_count: got %0d expected 1", drop_count); end
      n_tests++; if (rx_read !== 1'b1)    begin n_fail++; $display("FAIL clr_drop_ack: got %b expected 1", rx_read); end
      step();
      rx_done = 1'b0;
      step();
      // saturation: 1 + 260 drops must stop at 255
      for (int i = 0; i < 260; i++) send_byte(8'hC0);
      n_tests++; if (drop_count !== 8'd255) begin n_fail++; $display("FAIL sat_count: got %0d expected 255", drop_count); end
      clr_overrun = 1'b1;
      step();
      clr_overrun = 1'b0;
      n_tests++; if (drop_count !== 8'd0) begin n_fail++; $display("FAIL sat_clr_count: got %0d expected 0", drop_count); end
      for (int i = 0; i < 4; i++) pop_one();
      n_tests++; if (level !== '0) begin n_fail++; $display("FAIL ovr_level_empty: got %0d expected 0", level); end
   endtask

   task automatic test_full_pop();
      logic [7:0] exp_b;
      for (int b = 8'h11; b <= 8'h14; b++) send_byte(8'(b));
      rx_byte = 8'h77;
      rx_done = 1'b1;
      out_ready = 1'b1;
      exp_b = exp_q.pop_front();
      n_tests++; if (out_data !== exp_b) begin n_fail++; $display("FAIL fullpop_head: got %0h expected %0h", out_data, exp_b); end
      exp_q.push_back(8'h77);
      step();
      out_ready = 1'b0;
      n_tests++; if (level !== CW'(4)) begin n_fail++; $display("FAIL fullpop_level: got %0d expected 4", level); end
      n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL fullpop_overrun: got %b expected 0", overrun); end
      n_tests++; if (rx_read !== 1'b1) begin n_fail++; $display("FAIL fullpop_ack: got %b expected 1", rx_read); end
      step();
      rx_done = 1'b0;
      step();
      for (int i = 0; i < 4; i++) pop_one();
      n_tests++; if (level !== '0) begin n_fail++; $display("FAIL fullpop_level_empty: got %0d expected 0", level); end
   endtask

   // Run one idle scenario. Bytes rise at offset 0 and, when second_off >= 0,
   // again at second_off. Report the number of pulses and the first pulse offset.
   task automatic run_idle(input int second_off, input int span, input logic [7:0] b0,
                           input logic [7:0] b1, input logic [23:0] timeout,
                           output int npulse, output int first_off);
      npulse = 0;
      first_off = -1;
      for (int off = 0; off < span; off++) begin
         if (off == 0) begin
            idle_cycles = timeout;
            rx_byte = b0;
            rx_done = 1'b1;
            exp_q.push_back(b0);
            mlevel++;
         end else if (second_off >= 0 && off == second_off) begin
            rx_byte = b1;
            rx_done = 1'b1;
            exp_q.push_back(b1);
            mlevel++;
         end else if (off == 2 || (second_off >= 0 && off == second_off + 2)) begin
            rx_done = 1'b0;
         end
         #1;
         if (idle_pulse === 1'b1) begin
            if (npulse == 0) first_off = off;
            npulse++;
         end
         step();
      end
   endtask

   task automatic test_idle();
      int np;
      int fo;
      run_idle(-1, 200, 8'h31, 8'h00, 24'd100, np, fo);
      n_tests++; if (np != 1)   begin n_fail++; $display("FAIL idle_single_count: got %0d expected 1", np); end
      n_tests++; if (fo != 100) begin n_fail++; $display("FAIL idle_single_offset: got %0d expected 100", fo); end
      run_idle(60, 250, 8'h32, 8'h33, 24'd100, np, fo);
      n_tests++; if (np != 1)   begin n_fail++; $display("FAIL idle_retrig_count: got %0d expected 1", np); end
      n_tests++; if (fo != 160) begin n_fail++; $display("FAIL idle_retrig_offset: got %0d expected 160", fo); end
      run_idle(-1, 300, 8'h34, 8'h00, 24'd0, np, fo);
      n_tests++; if (np != 0)   begin n_fail++; $display("FAIL idle_disabled_count: got %0d expected 0", np); end
      for (int i = 0; i < 4; i++) pop_one();
      n_tests++; if (level !== '0) begin n_fail++; $display("FAIL idle_level_empty: got %0d expected 0", level); end
   endtask

   task automatic test_reset_ack();
      rx_byte = 8'h5C;
      rx_done = 1'b1;
      step();
      n_tests++; if (rx_read !== 1'b1) begin n_fail++; $display("FAIL rstack_ack: got %b expected 1", rx_read); end
      rst = 1'b0;
      step();
      n_tests++; if (rx_read !== 1'b0)  begin n_fail++; $display("FAIL rstack_rx_read: got %b expected 0", rx_read); end
      n_tests++; if (level !== '0)      begin n_fail++; $display("FAIL rstack_level: got %0d expected 0", level); end
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstack_valid: got %b expected 0", out_valid); end
      rst = 1'b1;
      exp_q.delete();
      exp_q.push_back(8'h5C);
      mlevel = 1;
      step();
      n_tests++; if (rx_read !== 1'b1) begin n_fail++; $display("FAIL rstack_recapture_ack: got %b expected 1", rx_read); end
      n_tests++; if (level !== CW'(1)) begin n_fail++; $display("FAIL rstack_recapture_level: got %0d expected 1", level); end
      step();
      rx_done = 1'b0;
      step();
      pop_one();
      n_tests++; if (level !== '0) begin n_fail++; $display("FAIL rstack_level_empty: got %0d expected 0", level); end
   endtask

   initial begin
      #1;
      test_reset();
      test_single_byte();
      test_fill_wrap();
      test_overrun();
      test_full_pop();
      test_idle();
      test_reset_ack();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer that sits directly downstream of the 8N1 UART receiver. It drains each completed byte from the receiver's done/read handshake within two cycles and stores it in a power-of-two FIFO. It presents the bytes to the consumer as a valid/ready stream, and reports overrun and line-idle conditions.

## Interface
- DEPTH, 16, FIFO entries; power of two, ≥2
- CW, $clog2(DEPTH)+1, width of level
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- rx_done  in  1  receiver byte-ready flag (level, held until acknowledged)
- rx_byte  in  8  receiver data, valid only while rx_done=1
- rx_read  out  1  registered one-cycle acknowledge to receiver
- out_valid  out  1  FIFO non-empty
- out_data  out  8  head byte; forced 0 when out_valid=0
- out_ready  in  1  consumer pop; pop occurs when out_valid && out_ready
- level  out  CW  current occupancy, 0..DEPTH
- overrun  out  1  sticky: byte dropped because FIFO full
- drop_count  out  8  dropped-byte count, saturates at 255
- clr_overrun  in  1  clears overrun and drop_count
- idle_cycles  in  24  idle timeout in clk cycles; 0 disables
- idle_pulse  out  1  one-cycle pulse: line idle after last byte

## Operation
- Capture FSM, states WAIT_DONE, ACK, CLEAR:
  - WAIT_DONE: on rx_done=1, sample rx_byte this cycle, push or drop, then go to ACK.
  - ACK: rx_read=1 for exactly this cycle, then go to CLEAR.
  - CLEAR: wait for rx_done=0, then go to WAIT_DONE. rx_read=0.
- The receiver clears rx_done on the edge ending the ACK cycle, so CLEAR normally lasts one cycle. No second capture occurs while rx_done stays high from the same byte.
- Push is accepted when level<DEPTH, or when level==DEPTH and a pop occurs in the same cycle.
- Otherwise the byte is dropped. It is still acknowledged. overrun←1 and drop_count increments, saturating at 255.
- Simultaneous push and pop: level unchanged, both pointers advance.
- Pop when empty is impossible because out_valid=0. There is no write-through bypass.
- Pointers are log2(DEPTH) bits and wrap naturally. level is tracked separately.
- clr_overrun clears overrun and drop_count. If a drop occurs in the same cycle, the drop wins: overrun=1 and drop_count=1.
- Idle timer:
  - Resets to 0 on every capture (push or drop).
  - Otherwise increments while armed.
  - Armed by a capture; disarmed when the pulse fires.
  - idle_pulse=1 for one cycle when the timer reaches idle_cycles−1, i.e. idle_cycles cycles after the capture cycle.
  - idle_cycles=0: never pulses, timer held at 0.

## Timing
- Reset values: rx_read=0, out_valid=0, out_data=0, level=0, overrun=0, drop_count=0, idle_pulse=0. FSM in WAIT_DONE, pointers 0, idle timer 0 and disarmed. FIFO contents are not reset.
- Capture latency: rx_done first seen high in cycle N.
  - Byte written at the end of N.
  - out_valid=1 and level updated in N+1.
  - rx_read=1 in N+1.
- Pop in cycle M: next head (or out_valid=0) visible in M+1.
- Minimum capture spacing is 3 cycles. UART bytes are ≥10 bit times apart, so the receiver is never back-pressured.
- Reset mid-operation (any state): all state returns to reset values on the next edge. Any byte pending in the receiver is captured after reset is released.

## Test plan
- Single byte: rx_done rises with rx_byte=0xA5 in cycle 10 -> rx_read=1 only in cycle 11; out_valid=1, out_data=0xA5, level=1 in cycle 11; pop with out_ready in cycle 12 -> out_valid=0 in cycle 13.
- Fill and wrap: DEPTH=4, push 0x01..0x04, pop two, push 0x05,0x06 -> pops yield 0x03,0x04,0x05,0x06 in order; level returns to 0.
- Overrun: DEPTH=4 full, three more bytes with no pops -> all three acknowledged, overrun=1, drop_count=3, FIFO still 0x01..0x04. clr_overrun -> both cleared next cycle.
- Full with simultaneous pop: level=4, out_ready=1 in the capture cycle of 0x77 -> accepted, level stays 4, overrun=0, 0x77 is the last entry.
- Idle: idle_cycles=100, single byte captured in cycle 20 -> idle_pulse=1 only in cycle 120. A second byte in cycle 80 -> pulse moves to cycle 180. idle_cycles=0 -> no pulse.
- Reset during ACK state -> rx_read=0, level=0 next cycle; the held rx_done is re-captured after reset is released.
